// File: rtl/expander_cmd_sequencer_pkg.sv
// Shared definitions for the expander command sequencer: opcodes, FSM
// encoding and the default output-port reset value.
package expander_pkg;

   localparam logic [7:0] OP_WRITE  = 8'h01;
   localparam logic [7:0] OP_READ   = 8'h02;
   localparam logic [7:0] OP_SET    = 8'h03;
   localparam logic [7:0] OP_CLR    = 8'h04;
   localparam logic [7:0] OP_PULSE  = 8'h05;
   localparam logic [7:0] OP_STATUS = 8'h06;
   localparam logic [7:0] OP_CLRERR = 8'h0F;

   localparam logic [7:0] RESET_VAL_DEF = 8'h00;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARG1    = 2'd1,
      ST_ARG2    = 2'd2,
      ST_DISCARD = 2'd3
   } state_t;

endpackage

// File: rtl/expander_cmd_sequencer_if.sv
// Byte-level link between the SPI slave (master modport) and the command
// sequencer (slave modport).
interface expander_cmd_sequencer_if;
   logic       ss_active;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic       tx_load;

   modport master (output ss_active, rx_valid, rx_data, input tx_data, tx_load);
   modport slave  (input ss_active, rx_valid, rx_data, output tx_data, tx_load);
endinterface

// File: rtl/expander_cmd_sequencer_pulse_timer.sv
// Timed-pulse engine: holds the active mask, counts the duration down and
// flags the cycle on which the pulse ends. A start overrides a running pulse.
module expander_pulse_timer #(
   parameter int PULSE_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               cancel,
   input  logic [7:0]         start_mask,
   input  logic [PULSE_W-1:0] start_dur,
   output logic               busy,
   output logic [7:0]         mask,
   output logic               expire
);

   logic [PULSE_W-1:0] cnt;

   // The counter's transition to zero is the expiry cycle.
   assign expire = busy && (cnt == PULSE_W'(1));

   // Counter, mask and busy flag; start beats cancel beats count-down.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         busy <= 1'b0;
         mask <= 8'h00;
      end else if (start) begin
         cnt  <= start_dur;
         busy <= 1'b1;
         mask <= start_mask;
      end else if (cancel) begin
         cnt  <= '0;
         busy <= 1'b0;
         mask <= 8'h00;
      end else if (busy) begin
         cnt <= cnt - PULSE_W'(1);
         if (cnt == PULSE_W'(1)) begin
            busy <= 1'b0;
            mask <= 8'h00;
         end
      end
   end

endmodule

// File: rtl/expander_cmd_sequencer.sv
// Expander command sequencer: parses opcode+payload frames from the SPI
// slave, owns the output port register, launches timed pulses and loads
// readback bytes. EXPANDER_STATUS_EN adds the STATUS opcode and cmd_cnt.
//
// state      | meaning
// -----------+---------------------------------------------------
// ST_IDLE    | waiting for the opcode byte of a frame
// ST_ARG1    | waiting for first payload byte (data or pulse mask)
// ST_ARG2    | waiting for pulse duration byte
// ST_DISCARD | command done or rejected; ignore bytes until ss drops
module expander_cmd_sequencer
   import expander_pkg::*;
#(
   parameter int         PULSE_W   = 8,
   parameter logic [7:0] RESET_VAL = RESET_VAL_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   expander_cmd_sequencer_if.slave  spi,
   output logic [7:0]               out_port,
   output logic                     pulse_busy,
   output logic                     err
);

   state_t             state, state_next;
   logic [7:0]         op_q, op_next;
   logic [7:0]         mask_q, mask_next;
   logic [7:0]         out_next;
   logic               err_next;
   logic [7:0]         tx_data_q, tx_data_next;
   logic               tx_load_q, tx_load_next;
   logic               t_start, t_cancel, t_expire;
   logic [7:0]         t_mask;
   logic [PULSE_W-1:0] t_dur;

`ifdef EXPANDER_STATUS_EN
   logic [5:0] cmd_cnt;
   logic       cmd_done;
`endif

   assign spi.tx_data = tx_data_q;
   assign spi.tx_load = tx_load_q;
   assign t_dur       = PULSE_W'(spi.rx_data);

   expander_pulse_timer #(.PULSE_W(PULSE_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .start      (t_start),
      .cancel     (t_cancel),
      .start_mask (mask_q),
      .start_dur  (t_dur),
      .busy       (pulse_busy),
      .mask       (t_mask),
      .expire     (t_expire)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   // Next-state and datapath decode; pulse expiry is applied before the
   // command result so a completing command wins.
   always_comb begin
      state_next   = state;
      op_next      = op_q;
      mask_next    = mask_q;
      out_next     = out_port;
      err_next     = err;
      tx_data_next = tx_data_q;
      tx_load_next = 1'b0;
      t_start      = 1'b0;
      t_cancel     = 1'b0;
      if (t_expire) out_next = out_port & ~t_mask;
      if (!spi.ss_active) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (spi.rx_valid) begin
               op_next    = spi.rx_data;
               state_next = ST_DISCARD;
               case (spi.rx_data)
                  OP_WRITE, OP_SET, OP_CLR, OP_PULSE: state_next = ST_ARG1;
                  OP_READ: begin
                     tx_data_next = out_port;
                     tx_load_next = 1'b1;
                  end
                  OP_CLRERR: err_next = 1'b0;
`ifdef EXPANDER_STATUS_EN
                  OP_STATUS: begin
                     tx_data_next = {err, pulse_busy, cmd_cnt};
                     tx_load_next = 1'b1;
                  end
`endif
                  default: err_next = 1'b1;
               endcase
            end
            ST_ARG1: if (spi.rx_valid) begin
               state_next = ST_DISCARD;
               case (op_q)
                  OP_WRITE: begin
                     out_next = spi.rx_data;
                     t_cancel = 1'b1;
                  end
                  OP_SET:   out_next = out_next | spi.rx_data;
                  OP_CLR:   out_next = out_next & ~spi.rx_data;
                  OP_PULSE: begin
                     mask_next  = spi.rx_data;
                     state_next = ST_ARG2;
                  end
                  default: ;
               endcase
            end
            ST_ARG2: if (spi.rx_valid) begin
               state_next = ST_DISCARD;
               if (t_dur != '0) begin
                  t_start  = 1'b1;
                  out_next = out_next | mask_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_port  <= RESET_VAL;
         err       <= 1'b0;
         tx_data_q <= 8'h00;
         tx_load_q <= 1'b0;
         op_q      <= 8'h00;
         mask_q    <= 8'h00;
      end else begin
         out_port  <= out_next;
         err       <= err_next;
         tx_data_q <= tx_data_next;
         tx_load_q <= tx_load_next;
         op_q      <= op_next;
         mask_q    <= mask_next;
      end
   end

`ifdef EXPANDER_STATUS_EN
   assign cmd_done = spi.ss_active && spi.rx_valid && (
         (state == ST_IDLE && (spi.rx_data == OP_READ || spi.rx_data == OP_CLRERR ||
                               spi.rx_data == OP_STATUS)) ||
         (state == ST_ARG1 && (op_q == OP_WRITE || op_q == OP_SET || op_q == OP_CLR)) ||
         (state == ST_ARG2));

   // Completed-command counter, wraps 63 -> 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          cmd_cnt <= 6'd0;
      else if (cmd_done) cmd_cnt <= cmd_cnt + 6'd1;
   end
`endif

endmodule

// File: tb/tb_expander_cmd_sequencer.sv
// Directed bench for expander_cmd_sequencer: a table of simple frames plus
// hand-written sequences for pulse timing, readback, aborts and reset.
module tb_expander_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] out_port;
   logic       pulse_busy;
   logic       err;
   int         n_checks = 0;
   int         n_fail   = 0;
   int         tx_cnt   = 0;

   expander_cmd_sequencer_if ifc ();

   expander_cmd_sequencer dut (
      .clk        (clk),
      .rst        (rst_n),
      .spi        (ifc),
      .out_port   (out_port),
      .pulse_busy (pulse_busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (ifc.tx_load === 1'b1) tx_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [7:0] b0, b1, b2;
      int         n;
      logic [7:0] exp_out;
      logic       exp_err;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      ifc.rx_valid = 1'b1;
      ifc.rx_data  = b;
      @(negedge clk);
      ifc.rx_valid = 1'b0;
   endtask

   task automatic frame_start();
      @(negedge clk);
      ifc.ss_active = 1'b1;
   endtask

   task automatic frame_end();
      @(negedge clk);
      ifc.ss_active = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n);
      frame_start();
      send_byte(b0);
      if (n > 1) send_byte(b1);
      if (n > 2) send_byte(b2);
      frame_end();
   endtask

   initial begin
      vecs[0] = '{8'h01, 8'hA5, 8'h00, 2, 8'hA5, 1'b0};
      vecs[1] = '{8'h01, 8'hF0, 8'h00, 2, 8'hF0, 1'b0};
      vecs[2] = '{8'h03, 8'h0F, 8'h00, 2, 8'hFF, 1'b0};
      vecs[3] = '{8'h04, 8'h81, 8'h00, 2, 8'h7E, 1'b0};
      vecs[4] = '{8'h77, 8'h01, 8'h33, 3, 8'h7E, 1'b1};
      vecs[5] = '{8'h0F, 8'h00, 8'h00, 1, 8'h7E, 1'b0};
      vecs[6] = '{8'h05, 8'h03, 8'h00, 3, 8'h7E, 1'b0};
      vecs[7] = '{8'h01, 8'h00, 8'h00, 2, 8'h00, 1'b0};
      vecs[8] = '{8'h01, 8'h5C, 8'h00, 2, 8'h5C, 1'b0};

      rst_n         = 1'b0;
      ifc.ss_active = 1'b0;
      ifc.rx_valid  = 1'b0;
      ifc.rx_data   = 8'h00;
      #12;
      check("reset out_port", out_port, 8'h00);
      check("reset err", {7'b0, err}, 8'h00);
      check("reset pulse_busy", {7'b0, pulse_busy}, 8'h00);
      check("reset tx_load", {7'b0, ifc.tx_load}, 8'h00);
      check("reset tx_data", ifc.tx_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Write timing: new value visible one cycle after the payload byte.
      frame_start();
      send_byte(8'h01);
      send_byte(8'h3C);
      check("write latency", out_port, 8'h3C);
      frame_end();

      for (int i = 0; i < 9; i++) begin
         run_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n);
         check($sformatf("vec%0d out_port", i), out_port, vecs[i].exp_out);
         check($sformatf("vec%0d err", i), {7'b0, err}, {7'b0, vecs[i].exp_err});
         check($sformatf("vec%0d pulse_busy", i), {7'b0, pulse_busy}, 8'h00);
      end

      // Readback with trailing bytes: one tx_load, bytes ignored.
      tx_cnt = 0;
      run_frame(8'h02, 8'h01, 8'h99, 3);
      check("read tx_data", ifc.tx_data, 8'h5C);
      check("read tx_load count", 8'(tx_cnt), 8'd1);
      check("read out_port kept", out_port, 8'h5C);

      // Aborted write: no change, next frame parses from IDLE.
      run_frame(8'h01, 8'h00, 8'h00, 1);
      check("abort out_port", out_port, 8'h5C);
      check("abort err", {7'b0, err}, 8'h00);
      run_frame(8'h01, 8'h11, 8'h00, 2);
      check("after abort write", out_port, 8'h11);

      // Pulse of 4 cycles from 0x00.
      run_frame(8'h01, 8'h00, 8'h00, 2);
      frame_start();
      send_byte(8'h05);
      send_byte(8'h03);
      send_byte(8'h04);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("pulse cyc%0d out_port", i), out_port, 8'h03);
         check($sformatf("pulse cyc%0d busy", i), {7'b0, pulse_busy}, 8'h01);
         @(negedge clk);
      end
      check("pulse end out_port", out_port, 8'h00);
      check("pulse end busy", {7'b0, pulse_busy}, 8'h00);
      frame_end();

      // Write during a running pulse cancels it and wins.
      run_frame(8'h01, 8'h11, 8'h00, 2);
      run_frame(8'h05, 8'hF0, 8'h0A, 3);
      check("long pulse out_port", out_port, 8'hF1);
      check("long pulse busy", {7'b0, pulse_busy}, 8'h01);
      frame_start();
      send_byte(8'h01);
      send_byte(8'h22);
      check("write cancels busy", {7'b0, pulse_busy}, 8'h00);
      check("write over pulse", out_port, 8'h22);
      frame_end();
      repeat (12) @(negedge clk);
      check("no late pulse clear", out_port, 8'h22);

      // Async reset mid-pulse with err set and tx_data non-zero.
      run_frame(8'h02, 8'h00, 8'h00, 1);
      run_frame(8'h77, 8'h00, 8'h00, 1);
      run_frame(8'h05, 8'hFF, 8'h08, 3);
      repeat (2) @(negedge clk);
      check("pre-reset busy", {7'b0, pulse_busy}, 8'h01);
      check("pre-reset err", {7'b0, err}, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst out_port", out_port, 8'h00);
      check("async rst busy", {7'b0, pulse_busy}, 8'h00);
      check("async rst err", {7'b0, err}, 8'h00);
      check("async rst tx_data", ifc.tx_data, 8'h00);
      check("async rst tx_load", {7'b0, ifc.tx_load}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      run_frame(8'h01, 8'h66, 8'h00, 2);
      check("post-reset write", out_port, 8'h66);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
